// File: rtl/dsm_pkg.sv
// Shared types and width helpers for the baseband interpolator datapath.
package dsm_pkg;

    localparam int unsigned DW_SAMPLE = 20;

    typedef enum logic [1:0] {
        FILL0,
        FILL1,
        RUN
    } interp_state_t;

    // Signed width needed to hold a dw-bit value grown by 'extra' bits plus a sign bit.
    function automatic int unsigned sdw(input int unsigned dw, input int unsigned extra);
        return dw + extra + 1;
    endfunction

endpackage

// File: rtl/interp_skid.sv
// One-entry look-ahead buffer in front of the interpolator; owns the input handshake.
module interp_skid #(
    parameter int unsigned DW = 20
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] sample_i,
    input  logic          sample_valid_i,
    input  logic          direct_i,
    input  logic          pop_i,
    output logic          sample_ready_o,
    output logic          xfer_o,
    output logic [DW-1:0] nxt_o,
    output logic          nxt_full_o
);

    logic          ready_en_q;
    logic          full_q, full_d;
    logic [DW-1:0] nxt_q, nxt_d;

    assign sample_ready_o = ready_en_q && !full_q;
    assign xfer_o         = sample_valid_i && sample_ready_o;
    assign nxt_o          = nxt_q;
    assign nxt_full_o     = full_q;

    // A transfer the consumer does not take directly parks in nxt.
    always_comb begin
        full_d = full_q;
        nxt_d  = nxt_q;
        if (pop_i) begin
            full_d = 1'b0;
        end else if (xfer_o && !direct_i) begin
            full_d = 1'b1;
            nxt_d  = sample_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ready_en_q <= 1'b0;
            full_q     <= 1'b0;
            nxt_q      <= '0;
        end else begin
            ready_en_q <= 1'b1;
            full_q     <= full_d;
            nxt_q      <= nxt_d;
        end
    end

endmodule

// File: rtl/linear_interp.sv
// Linear upsampling interpolator (ratio 2**L_LOG2) feeding the mixer's interp input.
// Define LINEAR_INTERP_UNDERRUN_CNT_EN to add the saturating underrun_cnt_o counter.
module linear_interp
    import dsm_pkg::*;
#(
    parameter int unsigned DW     = DW_SAMPLE,
    parameter int unsigned L_LOG2 = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] sample_i,
    input  logic          sample_valid_i,
    output logic          sample_ready_o,
    input  logic          tick_i,
    output logic [DW-1:0] interp_o,
    output logic          interp_stb_o,
    output logic          underrun_o
`ifdef LINEAR_INTERP_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt_o
`endif
);

    localparam int unsigned DELW = sdw(DW, 0);
    localparam int unsigned AW   = sdw(DW, L_LOG2);

    interp_state_t       state_q, state_d;
    logic [DW-1:0]       prev_q, prev_d;
    logic [DW-1:0]       curr_q, curr_d;
    logic [L_LOG2-1:0]   k_q, k_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [DW-1:0]       interp_q, interp_d;
    logic                stb_q, stb_d;
    logic                underrun_q, underrun_d;

    logic                xfer, direct, pop, wrap;
    logic                nxt_full;
    logic [DW-1:0]       nxt;
    logic [DELW-1:0]     delta;
    logic [AW-1:0]       delta_ext, acc_base, acc_shr;

    assign wrap   = (state_q == RUN) && tick_i && (&k_q);
    assign direct = (state_q != RUN) || (wrap && !nxt_full);
    assign pop    = wrap && nxt_full;

    interp_skid #(
        .DW(DW)
    ) u_skid (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .direct_i       (direct),
        .pop_i          (pop),
        .sample_ready_o (sample_ready_o),
        .xfer_o         (xfer),
        .nxt_o          (nxt),
        .nxt_full_o     (nxt_full)
    );

    assign delta     = {curr_q[DW-1], curr_q} - {prev_q[DW-1], prev_q};
    assign delta_ext = {{(AW - DELW){delta[DELW-1]}}, delta};
    assign acc_base  = {{(AW - DW){curr_q[DW-1]}}, curr_q} << L_LOG2;
    assign acc_shr   = $signed(acc_q) >>> L_LOG2;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        curr_d     = curr_q;
        k_d        = k_q;
        acc_d      = acc_q;
        interp_d   = interp_q;
        stb_d      = 1'b0;
        underrun_d = 1'b0;
        unique case (state_q)
            FILL0: begin
                if (xfer) begin
                    curr_d  = sample_i;
                    state_d = FILL1;
                end
            end
            FILL1: begin
                if (xfer) begin
                    prev_d  = curr_q;
                    curr_d  = sample_i;
                    k_d     = '0;
                    acc_d   = acc_base;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick_i) begin
                    interp_d = acc_shr[DW-1:0];
                    stb_d    = 1'b1;
                    k_d      = k_q + L_LOG2'(1);
                    if (wrap) begin
                        // New segment starts exactly at the old end point.
                        prev_d = curr_q;
                        acc_d  = acc_base;
                        if (nxt_full) begin
                            curr_d = nxt;
                        end else if (xfer) begin
                            curr_d = sample_i;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end else begin
                        acc_d = acc_q + delta_ext;
                    end
                end
            end
            default: state_d = FILL0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= FILL0;
            prev_q     <= '0;
            curr_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            interp_q   <= '0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            curr_q     <= curr_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            interp_q   <= interp_d;
            stb_q      <= stb_d;
            underrun_q <= underrun_d;
        end
    end

    assign interp_o     = interp_q;
    assign interp_stb_o = stb_q;
    assign underrun_o   = underrun_q;

`ifdef LINEAR_INTERP_UNDERRUN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (underrun_d && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign underrun_cnt_o = cnt_q;
`else
    // Default build only flags underruns; nothing is counted.
`endif

endmodule

// File: tb/tb_linear_interp.sv
// Scoreboard bench for linear_interp: random/directed stimulus against a closed-form reference.
module tb_linear_interp;

    localparam int DW = 20;
    localparam int L  = 3;
    localparam int R  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] sample_i;
    logic          sample_valid_i;
    logic          sample_ready_o;
    logic          tick_i;
    logic [DW-1:0] interp_o;
    logic          interp_stb_o;
    logic          underrun_o;
`ifdef LINEAR_INTERP_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    always #5 clk = ~clk;

    linear_interp #(
        .DW     (DW),
        .L_LOG2 (L)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .tick_i         (tick_i),
        .interp_o       (interp_o),
        .interp_stb_o   (interp_stb_o),
        .underrun_o     (underrun_o)
`ifdef LINEAR_INTERP_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o (underrun_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int src[$];
    int pend[$];
    int m_st, m_prev, m_curr, m_k, m_under;
    int obs_under = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: output k of a segment is floor((prev*R + k*(curr-prev))/R).
    task automatic model_step();
        bit xfer;
        int s;
        xfer = sample_valid_i && sample_ready_o;
        s = 0;
        if (xfer) s = src.pop_front();
        case (m_st)
            0: if (xfer) begin
                m_curr = s;
                m_st = 1;
            end
            1: if (xfer) begin
                m_prev = m_curr;
                m_curr = s;
                m_k = 0;
                m_st = 2;
            end
            default: begin
                if (xfer) pend.push_back(s);
                if (tick_i) begin
                    exp_q.push_back(fdiv(m_prev * R + m_k * (m_curr - m_prev), R));
                    if (m_k == R - 1) begin
                        m_prev = m_curr;
                        if (pend.size() > 0) m_curr = pend.pop_front();
                        else m_under++;
                    end
                    m_k = (m_k + 1) % R;
                end
            end
        endcase
    endtask

    // tick_per > 0: periodic ticks; 0: random ticks; < 0: no ticks.
    task automatic run_cycles(input int n, input int tick_per, input int valid_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid_i = (src.size() > 0) && ($urandom_range(99) < valid_pct);
            sample_i = (src.size() > 0) ? src[0][DW-1:0] : '0;
            if (tick_per > 0) tick_i = (cyc % tick_per == 0);
            else if (tick_per == 0) tick_i = ($urandom_range(99) < 25);
            else tick_i = 1'b0;
            cyc++;
            #4;
            model_step();
        end
    endtask

    task automatic apply_reset(input bool_async);
        if (!bool_async) @(negedge clk);
        rst_n = 1'b0;
        sample_valid_i = 1'b0;
        tick_i = 1'b0;
        #1;
        check("rst_interp", $signed(interp_o), 0);
        check("rst_stb", interp_stb_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_ready", sample_ready_o, 0);
        m_st = 0; m_prev = 0; m_curr = 0; m_k = 0; m_under = 0; obs_under = 0;
        pend.delete(); exp_q.delete(); src.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_release", sample_ready_o, 0);
        @(posedge clk);
        #1;
        check("ready_one_cycle_later", sample_ready_o, 1);
    endtask

    task automatic end_test(input string name);
        run_cycles(3, -1, 0);
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_underruns"}, obs_under, m_under);
`ifdef LINEAR_INTERP_UNDERRUN_CNT_EN
        check({name, "_underrun_cnt"}, underrun_cnt, m_under);
`endif
    endtask

    always @(negedge clk) begin
        int e;
        if (rst_n) begin
            if (interp_stb_o) begin
                if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("interp", $signed(interp_o), e);
                end
            end
            if (underrun_o) obs_under++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int v;
        int guard;
        rst_n = 1'b1;
        sample_i = '0;
        sample_valid_i = 1'b0;
        tick_i = 1'b0;

        apply_reset(1'b0);
        src = '{0, 800};
        repeat (20) src.push_back(800);
        run_cycles(4 * 12, 4, 100);
        end_test("ramp");

        apply_reset(1'b0);
        src = '{0, -3};
        repeat (10) src.push_back(-3);
        run_cycles(3 * 14, 3, 100);
        end_test("neg_floor");

        apply_reset(1'b0);
        src = '{524287, -524288};
        repeat (10) src.push_back(-524288);
        run_cycles(4 * 14, 4, 100);
        end_test("full_scale");

        apply_reset(1'b0);
        src = '{0, 800, 1600};
        run_cycles(4 * 20, 4, 100);
        end_test("underrun");

        apply_reset(1'b0);
        repeat (80) begin
            v = $urandom;
            src.push_back(v >>> 12);
        end
        run_cycles(1500, 0, 60);
        end_test("random");

        apply_reset(1'b0);
        repeat (60) begin
            v = $urandom;
            src.push_back(v >>> 12);
        end
        run_cycles(1500, 7, 100);
        end_test("backpressure");

        apply_reset(1'b0);
        src = '{0, 800};
        repeat (10) src.push_back(800);
        guard = 0;
        while (!(m_st == 2 && m_k == 5) && guard < 200) begin
            run_cycles(1, 4, 100);
            guard++;
        end
        check("reach_k5", (m_st == 2 && m_k == 5) ? 1 : 0, 1);
        @(posedge clk);
        #2;
        apply_reset(1'b1);
        run_cycles(30, 3, 0);
        src = '{10, 90};
        repeat (6) src.push_back(90);
        run_cycles(3 * 20, 3, 100);
        end_test("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
